micro32_loader: RTL and testbench

- Host-side program loader and result reader for the micro32 pipelined core.
- Streams a program/data image into core memory through a write port, clears PC, and releases the core.
- Waits for the core to halt, with a cycle timeout, then reads back a configurable memory window as an output stream.
- Replaces testbench backdoor writes to memory and PC/HALTED with synthesizable RTL.

---
 rtl/micro32_pkg.sv | 22 ++
 rtl/micro32_loader_rdbuf.sv | 25 ++
 rtl/micro32_loader.sv | 130 +++++++++++++
 tb/tb_micro32_loader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro32_pkg.sv
// Shared definitions for the micro32 host loader: state encoding, word width
// and the HLT opcode used by images that should stop the core.
package micro32_pkg;
  localparam int         WORD_W = 32;
  localparam logic [5:0] OP_HLT = 6'h3f;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_RUN,
    ST_DUMP_RD,
    ST_DUMP_CAP,
    ST_DUMP_OUT,
    ST_DONE
  } ldr_state_e;

  // States in which a new start may be accepted and the loader is not busy.
  function automatic logic is_quiet(ldr_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction
endpackage

// File: rtl/micro32_loader_rdbuf.sv
// Single-entry readback register: loads one word, holds it with valid
// until the consumer takes it.
module micro32_loader_rdbuf
  import micro32_pkg::*;
(
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] din,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data
);
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= din;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/micro32_loader.sv
// Host-side loader for the micro32 core: streams an image into memory, pulses
// PC clear, runs the core until halt or timeout, then streams a memory window out.
module micro32_loader
  import micro32_pkg::*;
#(
  parameter int                   ADDR_W    = 10,
  parameter int                   TIMEOUT_W = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'd50000
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W-1:0] dump_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              cpu_halted,
  output logic              cpu_pc_clr,
  output logic              cpu_run,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_wrap
);
  ldr_state_e state, state_nxt;

  logic [ADDR_W-1:0]    load_base_q, dump_base_q, dump_len_q;
  logic [ADDR_W-1:0]    cnt, idx, idx_inc;
  logic [TIMEOUT_W-1:0] timer, timer_inc;
  logic                 start_ok, s_hs, out_hs, tmo_hit;

  assign start_ok  = start && is_quiet(state);
  assign s_hs      = (state == ST_LOAD) && s_valid;
  assign out_hs    = (state == ST_DUMP_OUT) && m_valid && m_ready;
  assign idx_inc   = idx + 1'b1;
  assign timer_inc = timer + 1'b1;
  // Halt has priority over a timeout landing in the same cycle.
  assign tmo_hit   = (state == ST_RUN) && !cpu_halted && (timer_inc == TIMEOUT);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_ok) state_nxt = ST_LOAD;
      ST_LOAD:          if (s_valid && s_last) state_nxt = ST_RELEASE;
      ST_RELEASE:       state_nxt = ST_RUN;
      ST_RUN:
        if (cpu_halted || tmo_hit)
          state_nxt = (dump_len_q == '0) ? ST_DONE : ST_DUMP_RD;
      ST_DUMP_RD:       state_nxt = ST_DUMP_CAP;
      ST_DUMP_CAP:      state_nxt = ST_DUMP_OUT;
      ST_DUMP_OUT:
        if (out_hs) state_nxt = (idx_inc == dump_len_q) ? ST_DONE : ST_DUMP_RD;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    s_ready    = (state == ST_LOAD);
    mem_we     = s_hs;
    mem_re     = (state == ST_DUMP_RD);
    mem_wdata  = s_hs ? s_data : '0;
    mem_addr   = '0;
    if (state == ST_LOAD)    mem_addr = load_base_q + cnt;
    if (state == ST_DUMP_RD) mem_addr = dump_base_q + idx;
    cpu_pc_clr = (state == ST_RELEASE);
    cpu_run    = (state == ST_RUN);
    busy       = !is_quiet(state);
    done       = (state == ST_DONE);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      load_base_q <= '0;
      dump_base_q <= '0;
      dump_len_q  <= '0;
      cnt         <= '0;
      idx         <= '0;
      timer       <= '0;
      err_timeout <= 1'b0;
      err_wrap    <= 1'b0;
    end else begin
      if (start_ok) begin
        load_base_q <= load_base;
        dump_base_q <= dump_base;
        dump_len_q  <= dump_len;
        cnt         <= '0;
        idx         <= '0;
        err_timeout <= 1'b0;
        err_wrap    <= 1'b0;
      end
      if (s_hs) begin
        cnt <= cnt + 1'b1;
        if (&cnt) err_wrap <= 1'b1;
      end
      if (state == ST_RELEASE) timer <= '0;
      if (state == ST_RUN) begin
        timer <= timer_inc;
        if (tmo_hit) err_timeout <= 1'b1;
      end
      if (out_hs) idx <= idx_inc;
    end
  end

  micro32_loader_rdbuf u_rdbuf (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .load    (state == ST_DUMP_CAP),
    .din     (mem_rdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );
endmodule

// File: tb/tb_micro32_loader.sv
// Directed bench for micro32_loader with a 1024-word memory and a toy
// accumulator core that executes one instruction per cpu_run cycle.
module tb_micro32_loader;
  import micro32_pkg::*;

  localparam int AW = 10;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] load_base = '0, dump_base = '0, dump_len = '0;
  logic          s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [31:0]   s_data = '0;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          cpu_pc_clr, cpu_run;
  logic          m_valid, m_ready = 1'b1;
  logic [31:0]   m_data;
  logic          busy, done, err_timeout, err_wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk1 = ~clk1;

  micro32_loader #(.ADDR_W(AW), .TIMEOUT_W(16), .TIMEOUT(16'd100)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start),
    .load_base(load_base), .dump_base(dump_base), .dump_len(dump_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_halted(halted), .cpu_pc_clr(cpu_pc_clr), .cpu_run(cpu_run),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_wrap(err_wrap)
  );

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  localparam logic [31:0] HLT_W = {OP_HLT, 26'd0};

  // Memory plus toy core: 1 LDN, 2 LDI, 3 MULN, 4 DECN, 5 BNZ, 6 STA, 7 JMP, 3f HLT.
  logic [31:0] mem [0:1023] = '{default: {OP_HLT, 26'd0}};
  logic [9:0]  pc = '0;
  logic [31:0] acc = '0, nreg = '0;
  logic        halted = 1'b0;

  always @(posedge clk1) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (cpu_pc_clr) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (cpu_run && !halted) begin
      pc <= pc + 10'd1;
      case (mem[pc][31:26])
        6'h01: nreg <= mem[mem[pc][9:0]];
        6'h02: acc <= {16'd0, mem[pc][15:0]};
        6'h03: acc <= acc * nreg;
        6'h04: nreg <= nreg - 32'd1;
        6'h05: if (nreg != 0) pc <= mem[pc][9:0];
        6'h06: mem[mem[pc][9:0]] <= acc;
        6'h07: pc <= mem[pc][9:0];
        6'h3f: begin halted <= 1'b1; pc <= pc; end
        default: ;
      endcase
    end
  end

  // Passive monitor: logs handshakes and strobes; never cleared, tasks diff it.
  logic [31:0] got_q[$];
  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int re_cnt = 0, clr_cnt = 0, run_cnt = 0, both_cnt = 0, mv_cnt = 0;

  always @(posedge clk1) begin
    if (m_valid && m_ready) got_q.push_back(m_data);
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
    re_cnt   <= re_cnt + int'(mem_re);
    clr_cnt  <= clr_cnt + int'(cpu_pc_clr);
    run_cnt  <= run_cnt + int'(cpu_run);
    both_cnt <= both_cnt + int'(mem_we && mem_re);
    mv_cnt   <= mv_cnt + int'(m_valid);
  end

  logic [31:0] prog [0:1100];

  task automatic start_op(input logic [AW-1:0] lb, db, dl);
    @(negedge clk1);
    start = 1'b1; load_base = lb; dump_base = db; dump_len = dl;
    @(negedge clk1);
    start = 1'b0;
  endtask

  task automatic load_words(input int n, input bit toggle);
    int i = 0;
    int g = 0;
    while (i < n && g < 5000) begin
      @(negedge clk1);
      g++;
      if (toggle && (g % 2 == 0)) begin
        s_valid = 1'b0; s_last = 1'b0;
        continue;
      end
      s_valid = 1'b1; s_data = prog[i]; s_last = (i == n - 1);
      if (s_ready) i++;
    end
    @(negedge clk1);
    s_valid = 1'b0; s_last = 1'b0;
    if (i < n) begin
      errors++;
      $display("FAIL load_words: sent %0d words, required %0d", i, n);
    end
  endtask

  task automatic wait_done(input int budget);
    int g = 0;
    while (!done && g < budget) begin
      @(negedge clk1);
      g++;
    end
    if (!done) begin
      errors++;
      $display("FAIL wait_done: done still 0 after %0d cycles", budget);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk1);
    checks++;
    if ({s_ready, mem_we, mem_re, mem_addr, mem_wdata, cpu_pc_clr, cpu_run, m_valid,
         m_data, busy, done, err_timeout, err_wrap} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b run=%b m_valid=%b addr=%h", busy, done, cpu_run, m_valid, mem_addr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk1);
    checks++;
    if ({busy, done, cpu_run, s_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b run=%b s_ready=%b required 0", busy, done, cpu_run, s_ready);
    end
  endtask

  // Loads 7 at 200 with no dump; memory word 0 is HLT so the core stops at once.
  task automatic test_dump_zero;
    int w0 = wa_q.size(), c0 = clr_cnt, v0 = mv_cnt;
    prog[0] = 32'd7;
    start_op(10'd200, 10'd0, 10'd0);
    load_words(1, 1'b0);
    wait_done(200);
    checks++;
    if (wa_q.size() - w0 != 1 || wa_q[w0] !== 10'd200 || wd_q[w0] !== 32'd7) begin
      errors++;
      $display("FAIL load7_write: %0d writes, first addr %0d, required 1 write of 7 at 200", wa_q.size() - w0, wa_q[w0]);
    end
    checks++;
    if (clr_cnt - c0 != 1) begin
      errors++;
      $display("FAIL pc_clr_pulse: %0d pulses, required 1", clr_cnt - c0);
    end
    checks++;
    if (mv_cnt != v0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dump_len0: m_valid cycles %0d busy=%b, required 0 and 0", mv_cnt - v0, busy);
    end
  endtask

  task automatic test_factorial;
    int q0 = got_q.size();
    prog[0] = ins(6'h01, 16'd200);
    prog[1] = ins(6'h02, 16'd1);
    prog[2] = ins(6'h03, 16'd0);
    prog[3] = ins(6'h04, 16'd0);
    prog[4] = ins(6'h05, 16'd2);
    prog[5] = ins(6'h06, 16'd198);
    prog[6] = HLT_W;
    for (int i = 7; i < 11; i++) prog[i] = 32'd0;
    start_op(10'd0, 10'd198, 10'd3);
    load_words(11, 1'b0);
    wait_done(400);
    checks++;
    if (got_q.size() - q0 != 3) begin
      errors++;
      $display("FAIL fact_count: %0d words, required 3", got_q.size() - q0);
    end else begin
      checks++;
      if (got_q[q0] !== 32'd5040 || got_q[q0 + 2] !== 32'd7) begin
        errors++;
        $display("FAIL fact_data: got %0d,%0d required 5040,7", got_q[q0], got_q[q0 + 2]);
      end
    end
    checks++;
    if ({done, err_timeout, err_wrap} !== 3'b100) begin
      errors++;
      $display("FAIL fact_flags: done/tmo/wrap=%b required 100", {done, err_timeout, err_wrap});
    end
  endtask

  task automatic test_wrap;
    int w0 = wa_q.size();
    for (int i = 0; i < 4; i++) prog[i] = 32'hC0DE_0000 + i;
    start_op(10'd1020, 10'd0, 10'd0);
    load_words(4, 1'b1);
    wait_done(400);
    checks++;
    if (wa_q.size() - w0 != 4 || wa_q[w0] !== 10'd1020 || wa_q[w0 + 3] !== 10'd1023
        || wd_q[w0 + 3] !== 32'hC0DE_0003) begin
      errors++;
      $display("FAIL toggle_addrs: %0d writes first=%0d last=%0d, required 4 at 1020..1023", wa_q.size() - w0, wa_q[w0], wa_q[w0 + 3]);
    end
    checks++;
    if (err_wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_4words: err_wrap=%b required 0", err_wrap);
    end
    for (int i = 0; i < 1025; i++) prog[i] = HLT_W;
    w0 = wa_q.size();
    start_op(10'd0, 10'd0, 10'd0);
    load_words(1025, 1'b0);
    wait_done(200);
    checks++;
    if (err_wrap !== 1'b1 || wa_q[w0 + 1024] !== 10'd0) begin
      errors++;
      $display("FAIL wrap_1025: err_wrap=%b last addr=%0d, required 1 and 0", err_wrap, wa_q[w0 + 1024]);
    end
  endtask

  task automatic test_timeout;
    int q0 = got_q.size(), r0 = run_cnt;
    prog[0] = ins(6'h07, 16'd0);
    start_op(10'd0, 10'd0, 10'd1);
    load_words(1, 1'b0);
    wait_done(500);
    checks++;
    if (run_cnt - r0 != 100) begin
      errors++;
      $display("FAIL timeout_run_cycles: %0d required 100", run_cnt - r0);
    end
    checks++;
    if (err_timeout !== 1'b1 || err_wrap !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flag: err_timeout=%b err_wrap=%b required 1,0", err_timeout, err_wrap);
    end
    checks++;
    if (got_q.size() - q0 != 1 || got_q[q0] !== ins(6'h07, 16'd0)) begin
      errors++;
      $display("FAIL timeout_dump: %0d words first=%h required 1 word %h", got_q.size() - q0, got_q[q0], ins(6'h07, 16'd0));
    end
  endtask

  task automatic test_stall;
    int q0 = got_q.size(), g = 0, bad = 0, r0;
    prog[0] = HLT_W;
    prog[1] = 32'h1234_5678;
    m_ready = 1'b0;
    start_op(10'd0, 10'd0, 10'd2);
    load_words(2, 1'b0);
    while (!m_valid && g < 200) begin
      @(negedge clk1);
      g++;
    end
    r0 = re_cnt;
    repeat (10) begin
      @(negedge clk1);
      if (m_valid !== 1'b1 || m_data !== HLT_W) bad++;
    end
    checks++;
    if (bad != 0 || re_cnt != r0) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable cycles, %0d extra mem_re, required 0,0", bad, re_cnt - r0);
    end
    m_ready = 1'b1;
    wait_done(200);
    checks++;
    if (got_q.size() - q0 != 2 || got_q[q0] !== HLT_W || got_q[q0 + 1] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL stall_data: %0d words %h %h required %h 12345678", got_q.size() - q0, got_q[q0], got_q[q0 + 1], HLT_W);
    end
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_cleared: err_timeout=%b required 0", err_timeout);
    end
  endtask

  task automatic test_reset_in_run;
    int g = 0, q0;
    prog[0] = ins(6'h07, 16'd0);
    start_op(10'd0, 10'd0, 10'd1);
    load_words(1, 1'b0);
    while (!cpu_run && g < 50) begin
      @(negedge clk1);
      g++;
    end
    repeat (3) @(negedge clk1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_run, busy, done, s_ready, mem_we, mem_re, cpu_pc_clr, m_valid, err_timeout, err_wrap} !== '0) begin
      errors++;
      $display("FAIL reset_in_run: run=%b busy=%b done=%b required all 0", cpu_run, busy, done);
    end
    @(negedge clk1);
    rst_n = 1'b1;
    q0 = got_q.size();
    prog[0] = HLT_W;
    start_op(10'd0, 10'd0, 10'd1);
    load_words(1, 1'b0);
    wait_done(200);
    checks++;
    if (got_q.size() - q0 != 1 || got_q[q0] !== HLT_W || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_op: %0d words first=%h tmo=%b required 1 word %h tmo 0", got_q.size() - q0, got_q[q0], err_timeout, HLT_W);
    end
  endtask

  task automatic test_start_ignored;
    int w0 = wa_q.size(), q0 = got_q.size(), g = 0;
    prog[0] = HLT_W;
    prog[1] = 32'hAAAA_0001;
    prog[2] = 32'hBBBB_0002;
    start_op(10'd0, 10'd1, 10'd2);
    @(negedge clk1);
    start = 1'b1; load_base = 10'd500; dump_base = 10'd600; dump_len = 10'd0;
    @(negedge clk1);
    start = 1'b0;
    m_ready = 1'b0;
    load_words(3, 1'b0);
    checks++;
    if (wa_q.size() - w0 != 3 || wa_q[w0] !== 10'd0 || wa_q[w0 + 2] !== 10'd2) begin
      errors++;
      $display("FAIL start_in_load: first addr %0d last %0d required 0 and 2", wa_q[w0], wa_q[w0 + 2]);
    end
    while (!m_valid && g < 200) begin
      @(negedge clk1);
      g++;
    end
    start = 1'b1; dump_base = 10'd700; dump_len = 10'd5;
    @(negedge clk1);
    start = 1'b0;
    @(negedge clk1);
    checks++;
    if ({busy, m_valid, s_ready} !== 3'b110) begin
      errors++;
      $display("FAIL start_in_dump: busy/m_valid/s_ready=%b required 110", {busy, m_valid, s_ready});
    end
    m_ready = 1'b1;
    wait_done(200);
    checks++;
    if (got_q.size() - q0 != 2 || got_q[q0] !== 32'hAAAA_0001 || got_q[q0 + 1] !== 32'hBBBB_0002) begin
      errors++;
      $display("FAIL ignored_stream: %0d words %h %h required aaaa0001 bbbb0002", got_q.size() - q0, got_q[q0], got_q[q0 + 1]);
    end
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL we_re_exclusive: %0d cycles with both, required 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_dump_zero();
    test_factorial();
    test_wrap();
    test_timeout();
    test_stall();
    test_reset_in_run();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
